// File: rtl/morse_keyer_decoder_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | morse_keyer_decoder_if                                                |
// | Key input / symbol and character output bundle of the Morse decoder.  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface morse_keyer_decoder_if #(
  parameter int MAX_SYM = 6
);
  localparam int c_LEN_W = $clog2(MAX_SYM + 1);

  logic               enable;
  logic               key_in;
  logic               sym_valid;
  logic               sym_is_dash;
  logic               char_valid;
  logic [c_LEN_W-1:0] char_len;
  logic [MAX_SYM-1:0] char_bits;
  logic               char_err;
  logic               busy;

  modport master (
    output enable, key_in,
    input  sym_valid, sym_is_dash, char_valid, char_len, char_bits, char_err, busy
  );

  modport slave (
    input  enable, key_in,
    output sym_valid, sym_is_dash, char_valid, char_len, char_bits, char_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/morse_keyer_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | morse_keyer_decoder                                                   |
// | Times a raw key, classifies dots/dashes and assembles characters.     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module morse_keyer_decoder #(
  parameter int TICK_DIV    = 1000,
  parameter int DOT_MAX     = 20,
  parameter int MIN_PRESS   = 1,
  parameter int CHAR_GAP    = 30,
  parameter int MAX_SYM     = 6,
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  wire logic             clk,
  input  wire logic             rst,
  morse_keyer_decoder_if.slave  bus
);

  localparam int c_LEN_W = $clog2(MAX_SYM + 1);
  localparam int c_PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [c_PRE_W-1:0] c_PRE_LAST = c_PRE_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0]   c_DOT_MAX  = CNT_W'(DOT_MAX);
  localparam logic [CNT_W-1:0]   c_MIN      = CNT_W'(MIN_PRESS);
  localparam logic [CNT_W-1:0]   c_GAP      = CNT_W'(CHAR_GAP);
  localparam logic [c_LEN_W-1:0] c_CAP      = c_LEN_W'(MAX_SYM);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_PRESS = 2'd1;
  localparam logic [1:0] c_ST_GAP   = 2'd2;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [1:0]             r_state;
  logic [c_PRE_W-1:0]     r_presc;
  logic [CNT_W-1:0]       r_dur;
  logic [MAX_SYM-1:0]     r_buf;
  logic [c_LEN_W-1:0]     r_len;
  logic                   r_ovf;
  logic                   r_sym_valid;
  logic                   r_sym_dash;
  logic                   r_char_valid;
  logic [c_LEN_W-1:0]     r_char_len;
  logic [MAX_SYM-1:0]     r_char_bits;
  logic                   r_char_err;

  logic                   w_key_s;
  logic                   w_tick;
  logic [CNT_W-1:0]       w_dur_eff;
  logic                   w_is_dash;
  logic [1:0]             w_state_nxt;
  logic                   w_accept;
  logic                   w_emit;

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '0;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], bus.key_in};
  end

  assign w_key_s = r_sync[SYNC_STAGES-1];
  assign w_tick  = (r_presc == c_PRE_LAST);

  // Decisions include a tick landing on the deciding cycle, so a press of
  // N cycles counts as floor(N / TICK_DIV) ticks.
  assign w_dur_eff = (w_tick && !(&r_dur)) ? r_dur + 1'b1 : r_dur;
  assign w_is_dash = (w_dur_eff > c_DOT_MAX);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_emit      = 1'b0;
    case (r_state)
      c_ST_IDLE: begin
        if (w_key_s) w_state_nxt = c_ST_PRESS;
      end
      c_ST_PRESS: begin
        if (!w_key_s) begin
          if (w_dur_eff < c_MIN) begin
            w_state_nxt = (r_len != '0) ? c_ST_GAP : c_ST_IDLE;
          end else begin
            w_accept    = 1'b1;
            w_state_nxt = c_ST_GAP;
          end
        end
      end
      c_ST_GAP: begin
        // A key rise beats a gap expiry on the same cycle.
        if (w_key_s) begin
          w_state_nxt = c_ST_PRESS;
        end else if (w_tick && (w_dur_eff >= c_GAP)) begin
          w_emit      = 1'b1;
          w_state_nxt = c_ST_IDLE;
        end
      end
      default: w_state_nxt = c_ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !bus.enable) begin
      r_state      <= c_ST_IDLE;
      r_presc      <= '0;
      r_dur        <= '0;
      r_buf        <= '0;
      r_len        <= '0;
      r_ovf        <= 1'b0;
      r_sym_valid  <= 1'b0;
      r_char_valid <= 1'b0;
      // Flush via enable keeps the last reported symbol and character.
      if (rst) begin
        r_sym_dash  <= 1'b0;
        r_char_len  <= '0;
        r_char_bits <= '0;
        r_char_err  <= 1'b0;
      end
    end else begin
      r_sym_valid  <= 1'b0;
      r_char_valid <= 1'b0;
      r_state      <= w_state_nxt;

      if (w_state_nxt != r_state) begin
        r_presc <= '0;
        r_dur   <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        r_dur   <= w_dur_eff;
      end

      if (w_accept) begin
        r_sym_valid <= 1'b1;
        r_sym_dash  <= w_is_dash;
        if (r_len < c_CAP) begin
          r_buf[r_len] <= w_is_dash;
          r_len        <= r_len + 1'b1;
        end else begin
          r_ovf <= 1'b1;
        end
      end

      if (w_emit) begin
        r_char_valid <= 1'b1;
        r_char_len   <= r_len;
        r_char_bits  <= r_buf;
        r_char_err   <= r_ovf;
        r_buf        <= '0;
        r_len        <= '0;
        r_ovf        <= 1'b0;
      end
    end
  end

  assign bus.sym_valid   = r_sym_valid;
  assign bus.sym_is_dash = r_sym_dash;
  assign bus.char_valid  = r_char_valid;
  assign bus.char_len    = r_char_len;
  assign bus.char_bits   = r_char_bits;
  assign bus.char_err    = r_char_err;
  assign bus.busy        = (r_state != c_ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_morse_keyer_decoder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_morse_keyer_decoder                                                |
// | Directed bench; TICK_DIV=4 so one tick is 4 cycles (x250 time scale). |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_morse_keyer_decoder;

  localparam int c_MAX_SYM = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;

  morse_keyer_decoder_if #(.MAX_SYM(c_MAX_SYM)) bus ();

  morse_keyer_decoder #(
    .TICK_DIV(4), .DOT_MAX(20), .MIN_PRESS(1), .CHAR_GAP(30),
    .MAX_SYM(c_MAX_SYM), .CNT_W(8), .SYNC_STAGES(2)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   n_sym  = 0;
  int   n_char = 0;
  logic sym_hist [0:63];
  int   sb;
  int   cb;

  always @(negedge clk) begin
    if (bus.sym_valid) begin
      if (n_sym < 64) sym_hist[n_sym] = bus.sym_is_dash;
      n_sym = n_sym + 1;
    end
    if (bus.char_valid) n_char = n_char + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got === exp) n_pass = n_pass + 1;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic press(input int n);
    bus.key_in = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.key_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    sb = n_sym;
    cb = n_char;
  endtask

  initial begin
    bus.enable = 1'b1;
    bus.key_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_sym_valid", 32'(bus.sym_valid), 0);
    check("rst_sym_dash",  32'(bus.sym_is_dash), 0);
    check("rst_char_valid", 32'(bus.char_valid), 0);
    check("rst_char_len",  32'(bus.char_len), 0);
    check("rst_char_bits", 32'(bus.char_bits), 0);
    check("rst_char_err",  32'(bus.char_err), 0);
    check("rst_busy",      32'(bus.busy), 0);
    @(posedge clk); #1 rst = 1'b0;
    idle(4);

    // Letter A: dot then dash
    mark();
    bus.key_in = 1'b1;
    idle(10);
    @(negedge clk);
    check("a_busy_in_press", 32'(bus.busy), 1);
    @(posedge clk);
    press(29);
    idle(20);
    press(120);
    idle(200);
    check("a_sym_count", 32'(n_sym - sb), 2);
    check("a_sym0_dot",  32'(sym_hist[sb]), 0);
    check("a_sym1_dash", 32'(sym_hist[sb+1]), 1);
    check("a_char_count", 32'(n_char - cb), 1);
    check("a_char_len",  32'(bus.char_len), 2);
    check("a_char_bits", 32'(bus.char_bits), 32'b000010);
    check("a_char_err",  32'(bus.char_err), 0);
    check("a_busy_idle", 32'(bus.busy), 0);

    // Dot/dash boundary: 20 ticks is a dot, 21 ticks a dash
    mark();
    press(80);
    idle(200);
    check("b20_sym_count", 32'(n_sym - sb), 1);
    check("b20_is_dot",   32'(bus.sym_is_dash), 0);
    check("b20_char_len", 32'(bus.char_len), 1);
    check("b20_char_bits", 32'(bus.char_bits), 0);
    mark();
    press(84);
    idle(200);
    check("b21_sym_count", 32'(n_sym - sb), 1);
    check("b21_is_dash",  32'(bus.sym_is_dash), 1);
    check("b21_char_len", 32'(bus.char_len), 1);
    check("b21_char_bits", 32'(bus.char_bits), 1);

    // Overflow: seven dots into a six-symbol buffer
    mark();
    for (int i = 0; i < 7; i++) begin
      press(40);
      idle(20);
    end
    idle(160);
    check("ovf_sym_count",  32'(n_sym - sb), 7);
    check("ovf_char_count", 32'(n_char - cb), 1);
    check("ovf_char_len",   32'(bus.char_len), 6);
    check("ovf_char_bits",  32'(bus.char_bits), 0);
    check("ovf_char_err",   32'(bus.char_err), 1);
    press(40);
    idle(200);
    check("ovf_next_err", 32'(bus.char_err), 0);
    check("ovf_next_len", 32'(bus.char_len), 1);

    // Glitch from IDLE, then glitch mid-character
    mark();
    press(2);
    idle(10);
    check("gl_idle_sym",  32'(n_sym - sb), 0);
    check("gl_idle_busy", 32'(bus.busy), 0);
    idle(150);
    check("gl_idle_char", 32'(n_char - cb), 0);
    mark();
    press(40);
    idle(20);
    press(2);
    idle(200);
    check("gl_mid_sym",  32'(n_sym - sb), 1);
    check("gl_mid_char", 32'(n_char - cb), 1);
    check("gl_mid_len",  32'(bus.char_len), 1);

    // Enable drop during GAP: held character outputs survive
    press(120);
    idle(200);
    mark();
    press(40);
    idle(20);
    bus.enable = 1'b0;
    idle(10);
    bus.enable = 1'b1;
    idle(200);
    check("en_sym_count",  32'(n_sym - sb), 1);
    check("en_char_count", 32'(n_char - cb), 0);
    check("en_char_len",   32'(bus.char_len), 1);
    check("en_char_bits",  32'(bus.char_bits), 1);
    check("en_sym_dash",   32'(bus.sym_is_dash), 0);
    check("en_busy",       32'(bus.busy), 0);

    // Reset mid-press aborts everything
    mark();
    bus.key_in = 1'b1;
    idle(30);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    bus.key_in = 1'b0;
    @(negedge clk);
    check("rp_sym_dash",  32'(bus.sym_is_dash), 0);
    check("rp_char_len",  32'(bus.char_len), 0);
    check("rp_char_bits", 32'(bus.char_bits), 0);
    check("rp_busy",      32'(bus.busy), 0);
    idle(200);
    check("rp_sym_count",  32'(n_sym - sb), 0);
    check("rp_char_count", 32'(n_char - cb), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
